dma_rx_arbiter: RTL

- Packet-granular round-robin arbiter that shares the single DMA S2MM AXI-Stream channel between the two GT port receive streams (port 0, port 1).
- Sits between the per-port RX MAC/FIFO outputs and the DMA write channel inside the block design.
- Grant is held for a whole packet, so packets from the two ports never interleave.
- Also provides per-port packet counters and a software enable with graceful drain.

---
 rtl/dma_rx_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/dma_rx_arbiter.sv
// dma_rx_arbiter: packet-granular round-robin arbiter merging two RX AXI-Stream ports into one DMA S2MM stream.
// Optional build macro DMA_ARB_PRIO_EN: when defined, port 0 wins every tie (strict priority).
module dma_rx_arbiter #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int CNT_W  = 32
) (
    input  logic              bd_fclk0_125m,
    input  logic              reset_n,
    input  logic              arb_en,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic              s0_tlast,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic              s1_tlast,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t state, next_state;
    logic   rr_last;
    logic   pick1;
    logic   eop0, eop1;

`ifdef DMA_ARB_PRIO_EN
    assign pick1 = 1'b0;
`else
    assign pick1 = ~rr_last;
`endif

    assign eop0 = (state == BUSY0) && s0_tvalid && m_tready && s0_tlast;
    assign eop1 = (state == BUSY1) && s1_tvalid && m_tready && s1_tlast;

    // State, round-robin history and per-port packet counters
    always_ff @(posedge bd_fclk0_125m or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE)
                rr_last <= (next_state == BUSY1);
            if (eop0)
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            if (eop1)
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
        end
    end

    // Grant decision in IDLE; hold the grant until the granted port's last beat is accepted
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (arb_en) begin
                    if (s0_tvalid && s1_tvalid)
                        next_state = pick1 ? BUSY1 : BUSY0;
                    else if (s0_tvalid)
                        next_state = BUSY0;
                    else if (s1_tvalid)
                        next_state = BUSY1;
                end
            end
            BUSY0:   next_state = eop0 ? IDLE : BUSY0;
            BUSY1:   next_state = eop1 ? IDLE : BUSY1;
            default: next_state = IDLE;
        endcase
    end

    // Zero-latency pass-through of the granted port; everything quiet otherwise
    always_comb begin
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tlast   = 1'b0;
        m_tvalid  = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        grant     = 2'b00;
        busy      = 1'b0;
        case (state)
            BUSY0: begin
                m_tdata   = s0_tdata;
                m_tkeep   = s0_tkeep;
                m_tlast   = s0_tlast;
                m_tvalid  = s0_tvalid;
                s0_tready = m_tready;
                grant     = 2'b01;
                busy      = 1'b1;
            end
            BUSY1: begin
                m_tdata   = s1_tdata;
                m_tkeep   = s1_tkeep;
                m_tlast   = s1_tlast;
                m_tvalid  = s1_tvalid;
                s1_tready = m_tready;
                grant     = 2'b10;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
